seq_divider: RTL and testbench

Multi-cycle restoring integer divider: the inverse companion of the team's Wallace-tree multiplier in the processor's multiply/divide unit. Accepts a dividend/divisor pair on a start pulse, iterates one quotient bit per clock, and presents a registered quotient and remainder with a valid flag held until the next operation. The pipeline stalls on `busy` while a DIV/DIVU is in flight and reads `quotient`/`remainder` into LO/HI when `result_valid` rises.

---
 rtl/seq_divider.sv | 186 ++++++++++++++++++
 tb/tb_seq_divider.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
`default_nettype none
// =============================================================================
// Module   : seq_divider
// Purpose  : Multi-cycle restoring integer divider, one quotient bit per clock.
//            Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands.
// Revision : 1.0  initial release
// =============================================================================
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dz_q, dz_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic             div_zero_q, div_zero_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;

    logic             accept;
    logic [WIDTH:0]   part_rem;
    logic [WIDTH:0]   trial;
    logic             borrow;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] res_quo;
    logic [WIDTH-1:0] res_rem;

    assign accept   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    // dvd_q doubles as the quotient shift register: dividend bits leave at the
    // top while quotient bits enter at the bottom.
    assign part_rem = {rem_q, dvd_q[WIDTH-1]};
    assign trial    = part_rem - {1'b0, dvs_q};
    assign borrow   = trial[WIDTH];

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic q_neg_q, q_neg_d;
    logic r_neg_q, r_neg_d;

    assign dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
    assign dvs_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
    // Most-negative / -1 falls out naturally: magnitude 2^(WIDTH-1) negates to itself.
    assign res_quo = q_neg_q ? -dvd_q : dvd_q;
    assign res_rem = r_neg_q ? -rem_q : rem_q;

    always_comb begin
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        if (accept) begin
            q_neg_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_neg_d = dividend[WIDTH-1];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
        end else begin
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
        end
    end
`else
    assign dvd_mag = dividend;
    assign dvs_mag = divisor;
    assign res_quo = dvd_q;
    assign res_rem = rem_q;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        dz_d        = dz_q;
        busy_d      = busy_q;
        valid_d     = valid_q;
        div_zero_d  = div_zero_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    busy_d     = 1'b1;
                    valid_d    = 1'b0;
                    div_zero_d = 1'b0;
                    if (divisor == '0) begin
                        // Raw dividend kept: it is returned unchanged as the remainder.
                        dz_d    = 1'b1;
                        dvd_d   = dividend;
                        state_d = S_FIX;
                    end else begin
                        dz_d    = 1'b0;
                        dvd_d   = dvd_mag;
                        dvs_d   = dvs_mag;
                        rem_d   = '0;
                        cnt_d   = CNT_W'(WIDTH - 1);
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                rem_d = borrow ? part_rem[WIDTH-1:0] : trial[WIDTH-1:0];
                dvd_d = {dvd_q[WIDTH-2:0], ~borrow};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (dz_q) begin
                    quotient_d  = '1;
                    remainder_d = dvd_q;
                end else begin
                    quotient_d  = res_quo;
                    remainder_d = res_rem;
                end
                div_zero_d = dz_q;
                busy_d     = 1'b0;
                valid_d    = 1'b1;
                state_d    = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            dz_q        <= 1'b0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            div_zero_q  <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            dz_q        <= dz_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
            div_zero_q  <= div_zero_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    assign busy         = busy_q;
    assign result_valid = valid_q;
    assign div_zero     = div_zero_q;
    assign quotient     = quotient_q;
    assign remainder    = remainder_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// =============================================================================
// Module   : tb_seq_divider
// Purpose  : Self-checking bench for seq_divider, directed plus random operands.
// Revision : 1.0  initial release
// =============================================================================
module tb_seq_divider;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         result_valid;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_zero;

    int n_checks = 0;
    int n_pass   = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .dividend     (dividend),
        .divisor      (divisor),
        .busy         (busy),
        .result_valid (result_valid),
        .quotient     (quotient),
        .remainder    (remainder),
        .div_zero     (div_zero)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: plain arithmetic division with the documented corner cases.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
        logic signed [W-1:0] sa, sb;
        logic [W-1:0] min_neg;
        sa = a;
        sb = b;
        min_neg = {1'b1, {(W-1){1'b0}}};
        dz = (b == '0);
        if (dz) begin
            q = '1;
            r = a;
        end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
            if (a == min_neg && b == '1) begin
                q = min_neg;
                r = '0;
            end else begin
                q = sa / sb;
                r = sa % sb;
            end
`else
            q = a / b;
            r = a % b;
`endif
        end
    endtask

    // chained: start is already high with a/b applied and the DUT sits in DONE.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit chained,
                          input int glitch_at, input bit hold_next,
                          input logic [W-1:0] na, input logic [W-1:0] nb);
        logic [W-1:0] eq, er;
        logic edz;
        int cyc, exp_lat, busy_bad;
        model(a, b, eq, er, edz);
        exp_lat = (b == '0) ? 1 : W + 1;
        if (!chained) begin
            start    = 1'b1;
            dividend = a;
            divisor  = b;
        end
        @(posedge clock); #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        check("accept_busy", busy, 1);
        check("accept_valid", result_valid, 0);
        cyc = 0;
        busy_bad = 0;
        while (!result_valid && cyc < 3 * W) begin
            if (glitch_at > 0 && cyc == glitch_at) begin
                start    = 1'b1;
                dividend = $urandom;
                divisor  = $urandom | 1;
            end else if (glitch_at > 0 && cyc == glitch_at + 1) begin
                start = 1'b0;
            end
            if (hold_next && cyc == exp_lat - 3) begin
                start    = 1'b1;
                dividend = na;
                divisor  = nb;
            end
            @(posedge clock); #1;
            cyc++;
            if (!result_valid && !busy) busy_bad++;
        end
        check("latency", cyc, exp_lat);
        check("busy_gap", busy_bad, 0);
        check("quotient", quotient, eq);
        check("remainder", remainder, er);
        check("div_zero", div_zero, edz);
        check("done_busy", busy, 0);
    endtask

    initial begin
        logic [W-1:0] a, b, na, nb;
        bit chain, hold;

        #1;
        check("rst_busy", busy, 0);
        check("rst_valid", result_valid, 0);
        check("rst_dz", div_zero, 0);
        check("rst_q", quotient, 0);
        check("rst_r", remainder, 0);
        @(posedge clock); #1;
        reset_n = 1'b1;

        run_op(32'd100, 32'd7, 0, 0, 0, '0, '0);
        repeat (3) @(posedge clock);
        #1;
        check("hold_valid", result_valid, 1);
        check("hold_q", quotient, 14);

        run_op(32'hFFFF_FFFF, 32'd1, 0, 0, 1, 32'd5, 32'd9);
        run_op(32'd5, 32'd9, 1, 0, 0, '0, '0);
        run_op(32'd1234, 32'd0, 0, 0, 0, '0, '0);
`ifdef SEQ_DIVIDER_SIGNED_EN
        run_op(-32'sd7, 32'd2, 0, 0, 0, '0, '0);
        run_op(32'd7, -32'sd2, 0, 0, 0, '0, '0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, '0, '0);
        run_op(-32'sd1234, 32'd0, 0, 0, 0, '0, '0);
`endif
        run_op(32'd100, 32'd7, 0, 10, 0, '0, '0);

        // Asynchronous reset in the middle of an operation.
        start = 1'b1; dividend = 32'd100; divisor = 32'd7;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (14) @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", result_valid, 0);
        check("mid_rst_dz", div_zero, 0);
        check("mid_rst_q", quotient, 0);
        check("mid_rst_r", remainder, 0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        run_op(32'd100, 32'd7, 0, 0, 0, '0, '0);

        chain = 1'b0;
        a = '0; b = '0;
        for (int i = 0; i < 30; i++) begin
            if (!chain) begin
                a = $urandom;
                case ($urandom_range(0, 7))
                    0:       b = '0;
                    1, 2:    b = $urandom_range(1, 15);
                    3:       b = '1;
                    default: b = $urandom >> $urandom_range(0, 28);
                endcase
            end
            na = $urandom;
            nb = $urandom >> $urandom_range(0, 30);
            hold = (b != '0) && ($urandom_range(0, 2) == 0);
            run_op(a, b, chain, 0, hold, na, nb);
            chain = hold;
            if (hold) begin
                a = na;
                b = nb;
            end
        end
        if (chain) run_op(a, b, 1, 0, 0, '0, '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
